// File: rtl/fifo_nibble_packer.sv
// Pops 4-bit nibbles from a FIFO and packs them LSB-first into NIBBLES-wide words.
// Each word is offered on a valid/ready port with a count and an even-parity bit.
module fifo_nibble_packer #(
    parameter int NIBBLES = 4,
    parameter int CNT_W   = $clog2(NIBBLES + 1)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 fifo_empty,
    input  logic [3:0]           fifo_read_data,
    output logic                 fifo_read_en,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_data,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_parity,
    output logic                 busy
);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4*NIBBLES-1:0] data_q, data_d;
    logic                 pop_s;
    logic                 hold_s;

    function automatic logic even_parity(input logic [4*NIBBLES-1:0] word);
        return ^word;
    endfunction

    assign hold_s = (state_q == ST_HOLD);
    // Gated by rstN so the FIFO is never popped while the packer is in reset.
    assign pop_s        = rstN && (state_q == ST_FILL) && !fifo_empty;
    assign fifo_read_en = pop_s;

    // Next-state logic for FSM, nibble count and packed word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_FILL: begin
                if (pop_s) begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            data_d[4*k +: 4] = fifo_read_data;
                        end else begin
                            data_d[4*k +: 4] = data_q[4*k +: 4];
                        end
                    end
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
                // A flush coincident with a pop emits the word including that nibble.
                if ((pop_s && (cnt_q == CNT_W'(NIBBLES - 1))) ||
                    (flush && ((cnt_q != {CNT_W{1'b0}}) || pop_s))) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_FILL;
                    cnt_d   = {CNT_W{1'b0}};
                    data_d  = {(4*NIBBLES){1'b0}};
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_FILL;
                cnt_d   = {CNT_W{1'b0}};
                data_d  = {(4*NIBBLES){1'b0}};
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_FILL;
            cnt_q   <= {CNT_W{1'b0}};
            data_q  <= {(4*NIBBLES){1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign out_valid  = hold_s;
    assign out_data   = hold_s ? data_q : {(4*NIBBLES){1'b0}};
    assign out_count  = hold_s ? cnt_q : {CNT_W{1'b0}};
    assign out_parity = hold_s ? even_parity(data_q) : 1'b0;
    assign busy       = (cnt_q != {CNT_W{1'b0}}) || hold_s;

endmodule

// File: doc/fifo_nibble_packer.md
# fifo_nibble_packer

Downstream consumer of the 4-bit nibble FIFO. It pops nibbles whenever the FIFO is non-empty and assembles them LSB-first into a `NIBBLES`-wide word. Each word is presented on a valid/ready output port with a nibble count and an even-parity bit. A `flush` input emits a partially filled word, so tail data never strands in the packer.

## Interface

Parameters:
- `NIBBLES`, default 4: nibbles per output word; legal range ≥2.
- `CNT_W`, default `$clog2(NIBBLES+1)`: width of the nibble count; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rstN` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_read_data` in 4: FIFO head nibble; combinational, valid whenever `fifo_empty`=0.
- `fifo_read_en` out 1: pop strobe to FIFO; combinational.
- `flush` in 1: single-cycle request to emit the current partial word.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts word.
- `out_data` out 4*NIBBLES: packed word; nibble k occupies bits [4k+3:4k].
- `out_count` out CNT_W: number of valid nibbles in `out_data`, 1..NIBBLES.
- `out_parity` out 1: XOR of all bits of `out_data`, so data plus parity has even parity.
- `busy` out 1: high when the internal nibble count is >0 or state is HOLD.

## Operation

- Two-state FSM: FILL and HOLD. Reset state is FILL.
- Internal registers:
  - `data_q`: 4*NIBBLES bits.
  - `cnt_q`: CNT_W bits, counts nibbles held.
- FILL:
  - `fifo_read_en` = !fifo_empty. The block never pops an empty FIFO.
  - On pop: `data_q[4*cnt_q +: 4]` <= `fifo_read_data`; `cnt_q` <= `cnt_q`+1.
  - Go to HOLD when the pop makes `cnt_q` reach NIBBLES.
  - Go to HOLD on `flush` when `cnt_q`>0 or a pop occurs in the same cycle. A coincident pop is included in the emitted word.
  - `flush` with `cnt_q`=0 and no pop is ignored; no state change.
  - `flush` outside FILL is ignored; it is not queued.
- HOLD:
  - `fifo_read_en`=0.
  - `out_valid`=1. `out_data`, `out_count` and `out_parity` are held stable until accepted.
  - On `out_valid && out_ready`: go to FILL, `cnt_q` <= 0, `data_q` <= 0.
- Unfilled nibble slots of a flushed word read 0.
- `out_count` = `cnt_q` in HOLD and 0 in FILL.
- `out_data` = `data_q` in HOLD and 0 in FILL.
- `out_parity` = ^`out_data`; 0 in FILL.
- Arithmetic: `cnt_q` never exceeds NIBBLES; no wrap.

## Timing

- Reset (async assert, sync-safe deassert by system):
  - State FILL, `cnt_q`=0, `data_q`=0.
  - `out_valid`=0, `out_data`=0, `out_count`=0, `out_parity`=0, `busy`=0.
  - `fifo_read_en` follows `fifo_empty` immediately after reset.
- Reset mid-operation discards the partial or held word; no output handshake completes.
- Pop-to-valid latency: `out_valid` rises the cycle after the edge that captures the last nibble (or the flush).
- Peak throughput is one word per NIBBLES+1 cycles. The HOLD→FILL return costs one cycle with no pop.
- Backpressure: `out_ready` low holds HOLD indefinitely. The FIFO fills and asserts full; no data loss.
- `out_ready` is ignored in FILL.
- `fifo_read_en` is combinational from state and `fifo_empty`. There is no combinational path from `out_ready` to `fifo_read_en`.

## Test plan

- Reset:
  - Stimulus: assert `rstN`=0 mid-cycle with FIFO non-empty.
  - Response: all outputs at their reset values asynchronously, `fifo_read_en`=0 while in reset, `busy`=0.
- Full word:
  - Stimulus: FIFO supplies 0x1, 0x2, 0x3, 0x4 back-to-back with `out_ready`=1.
  - Response: four pop cycles, then `out_valid`=1 for one cycle with `out_data`=16'h4321, `out_count`=4, `out_parity`=1.
- Backpressure:
  - Stimulus: same word with `out_ready`=0 for 5 cycles after valid, FIFO holding 0x5.
  - Response: `fifo_read_en`=0 and `out_data` stable for 5 cycles; accept on the 6th; the next cycle pops 0x5.
- Flush partial:
  - Stimulus: pop 0xA then 0xB, FIFO empty, pulse `flush`.
  - Response: next cycle `out_valid`=1, `out_data`=16'h00BA, `out_count`=2, `out_parity`=1.
- Flush edge cases:
  - Stimulus: `flush` with `cnt_q`=0 and FIFO empty.
  - Response: no valid, no state change.
  - Stimulus: `flush` coincident with pop of 0x7 after 0x6.
  - Response: word 16'h0076, `out_count`=2.
- Reset mid-fill:
  - Stimulus: assert `rstN` low after 3 pops.
  - Response: `busy`=0; the next word starts at slot 0, and the 3 discarded nibbles never appear.
